// File: rtl/dcache_tag_pkg.sv
// dcache_tag_pkg: shared definitions for the data-cache tag controller.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default tag entry width / index width
//   state_t                         : controller FSM encoding (CLEAR, RUN)
package dcache_tag_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 26;
  localparam int unsigned DEF_ADDR_WIDTH = 5;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/dcache_tag_clr.sv
// dcache_tag_clr: clear sequencer for the tag RAM.
//   clk_i, rst_i : clock, synchronous active-high reset (counter -> 0)
//   restart      : force the counter back to 0
//   en           : advance one index per cycle
//   cnt          : index being cleared this cycle
//   done         : last index (depth-1) is being cleared this cycle
module dcache_tag_clr
  import dcache_tag_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  restart,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] cnt,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Natural wrap at depth-1 leaves the counter at 0 for the next clear.
  always_ff @(posedge clk_i) begin
    if (rst_i || restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + ONE;
    end
  end

  always_comb begin
    done = en && (cnt == '1);
  end

endmodule

// File: rtl/dcache_tag_ctrl.sv
// dcache_tag_ctrl: tag RAM controller for a 1W/1R macro with active-low selects.
// After reset (or a flush) every entry is written with zero, one index per
// cycle, while busy_o is high; afterwards lookups and writes pass through,
// one of each per cycle.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   flush_i           : pulse in RUN restarts the clear sequence
//   lookup_*          : read request / accept / one-cycle-later response
//   wr_*              : write request / accept
//   busy_o            : clear sequence in progress
//   ram_*0_o          : RAM write port; ram_*1_o / ram_dout1_i : RAM read port
// Build option: define DCACHE_TAG_BYPASS_EN to forward write data to a
// same-cycle, same-index lookup; otherwise such a lookup is stalled.
module dcache_tag_ctrl
  import dcache_tag_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  lookup_valid_i,
  input  logic [ADDR_WIDTH-1:0] lookup_idx_i,
  output logic                  lookup_accept_o,
  output logic                  lookup_rvalid_o,
  output logic [DATA_WIDTH-1:0] lookup_data_o,
  input  logic                  wr_valid_i,
  input  logic [ADDR_WIDTH-1:0] wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_accept_o,
  output logic                  busy_o,
  output logic                  ram_csb0_o,
  output logic [ADDR_WIDTH-1:0] ram_addr0_o,
  output logic [DATA_WIDTH-1:0] ram_din0_o,
  output logic                  ram_csb1_o,
  output logic [ADDR_WIDTH-1:0] ram_addr1_o,
  input  logic [DATA_WIDTH-1:0] ram_dout1_i
);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    clr_done;
  logic                    clearing;
  logic                    running;
  logic                    collide;
  logic                    ram_rd;
  logic                    rvalid_q;

  dcache_tag_clr #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .restart(running && flush_i),
    .en     (clearing),
    .cnt    (clr_cnt),
    .done   (clr_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_CLEAR;
    end else begin
      case (state)
        ST_CLEAR: if (clr_done) state <= ST_RUN;
        ST_RUN:   if (flush_i)  state <= ST_CLEAR;
        default:  state <= ST_CLEAR;
      endcase
    end
  end

  // Reset is synchronous, but the reset cycle itself must already present
  // idle selects and no accepts, so rst_i also gates the outputs directly.
  always_comb begin
    clearing = (state == ST_CLEAR) && !rst_i;
    running  = (state == ST_RUN) && !rst_i;
    collide  = wr_valid_i && lookup_valid_i && (wr_idx_i == lookup_idx_i);
  end

  always_comb begin
    busy_o      = rst_i || (state == ST_CLEAR);
    wr_accept_o = running && wr_valid_i;
`ifdef DCACHE_TAG_BYPASS_EN
    lookup_accept_o = running && lookup_valid_i;
    ram_rd          = lookup_accept_o && !collide;
`else
    lookup_accept_o = running && lookup_valid_i && !collide;
    ram_rd          = lookup_accept_o;
`endif
    ram_csb0_o  = !(clearing || wr_accept_o);
    ram_addr0_o = clearing ? clr_cnt : wr_idx_i;
    ram_din0_o  = clearing ? '0 : wr_data_i;
    ram_csb1_o  = !ram_rd;
    ram_addr1_o = lookup_idx_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= lookup_accept_o;
    end
  end

`ifdef DCACHE_TAG_BYPASS_EN
  logic                  byp_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  // A colliding lookup skips the RAM read and returns the write data instead.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_q      <= lookup_accept_o && collide;
      byp_data_q <= wr_data_i;
    end
  end

  always_comb begin
    lookup_rvalid_o = rvalid_q && !rst_i;
    lookup_data_o   = '0;
    if (lookup_rvalid_o) lookup_data_o = byp_q ? byp_data_q : ram_dout1_i;
  end
`else
  always_comb begin
    lookup_rvalid_o = rvalid_q && !rst_i;
    lookup_data_o   = '0;
    if (lookup_rvalid_o) lookup_data_o = ram_dout1_i;
  end
`endif

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
module tb_dcache_tag_ctrl;

  localparam int unsigned DW = 26;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          lv = 1'b0;
  logic [AW-1:0] lidx = '0;
  logic          lacc;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          wv = 1'b0;
  logic [AW-1:0] widx = '0;
  logic [DW-1:0] wdata = '0;
  logic          wacc;
  logic          busy;
  logic          csb0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic          csb1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] dout1;

  int unsigned tests = 0;
  int unsigned errors = 0;

  logic [DW-1:0] mem [32];

  always #5 clk = ~clk;

  dcache_tag_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .lookup_valid_i (lv),
    .lookup_idx_i   (lidx),
    .lookup_accept_o(lacc),
    .lookup_rvalid_o(rvalid),
    .lookup_data_o  (rdata),
    .wr_valid_i     (wv),
    .wr_idx_i       (widx),
    .wr_data_i      (wdata),
    .wr_accept_o    (wacc),
    .busy_o         (busy),
    .ram_csb0_o     (csb0),
    .ram_addr0_o    (addr0),
    .ram_din0_o     (din0),
    .ram_csb1_o     (csb1),
    .ram_addr1_o    (addr1),
    .ram_dout1_i    (dout1)
  );

  // 1W/1R RAM with registered read data.
  initial begin
    for (int k = 0; k < 32; k++) mem[k] = '1;
    dout1 = '0;
  end

  always @(posedge clk) begin
    if (!csb0) mem[addr0] <= din0;
    if (!csb1) dout1 <= mem[addr1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called at the start of what must be the first clear cycle.
  task automatic run_clear(input bit pulse_flush);
    for (int i = 0; i < 32; i++) begin
      lv    = 1'b1;
      wv    = 1'b1;
      lidx  = 5'd2;
      widx  = 5'd6;
      flush = pulse_flush && (i == 10);
      #1;
      check("clr_busy", {31'd0, busy}, 32'd1);
      check("clr_wport", {csb0, addr0, din0}, {1'b0, 5'(i), 26'd0});
      check("clr_noacc", {29'd0, lacc, wacc, csb1}, 32'd1);
      cyc();
    end
    lv    = 1'b0;
    wv    = 1'b0;
    flush = 1'b0;
    #1;
    check("clr_end_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset with requests pending: nothing may be accepted or selected.
    lv = 1'b1; wv = 1'b1; lidx = 5'd4; widx = 5'd4;
    cyc();
    #1;
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_sel", {30'd0, csb0, csb1}, 32'd3);
    check("rst_acc", {29'd0, lacc, wacc, rvalid}, 32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    run_clear(1'b0);

    // Lookup after clear returns zero.
    lv = 1'b1; lidx = 5'd7;
    #1;
    check("lk7_acc", {25'd0, lacc, csb1, addr1}, {25'd0, 1'b1, 1'b0, 5'd7});
    cyc();
    lv = 1'b0;
    #1;
    check("lk7_resp", {5'd0, rvalid, rdata}, {5'd0, 1'b1, 26'd0});
    cyc();
    check("lk7_idle", {5'd0, rvalid, rdata}, 32'd0);

    // Write then read-after-write on next cycle.
    wv = 1'b1; widx = 5'd3; wdata = 26'h2AAAAAA;
    #1;
    check("wr3_port", {wacc, csb0, addr0, din0}, {1'b1, 1'b0, 5'd3, 26'h2AAAAAA});
    cyc();
    wv = 1'b0; lv = 1'b1; lidx = 5'd3;
    #1;
    check("rd3_acc", {31'd0, lacc}, 32'd1);
    cyc();
    lv = 1'b0;
    #1;
    check("rd3_resp", {5'd0, rvalid, rdata}, {5'd0, 1'b1, 26'h2AAAAAA});

    // Same-cycle write and lookup on index 5.
    cyc();
    wv = 1'b1; widx = 5'd5; wdata = 26'h1234567;
    lv = 1'b1; lidx = 5'd5;
    #1;
`ifdef DCACHE_TAG_BYPASS_EN
    check("col_acc", {28'd0, lacc, wacc, csb0, csb1}, {28'd0, 4'b1101});
    cyc();
    wv = 1'b0; lv = 1'b0;
    #1;
    check("col_resp", {5'd0, rvalid, rdata}, {5'd0, 1'b1, 26'h1234567});
`else
    check("col_acc", {28'd0, lacc, wacc, csb0, csb1}, {28'd0, 4'b0101});
    cyc();
    wv = 1'b0;
    #1;
    check("col_retry", {31'd0, lacc}, 32'd1);
    cyc();
    lv = 1'b0;
    #1;
    check("col_resp", {5'd0, rvalid, rdata}, {5'd0, 1'b1, 26'h1234567});
`endif

    // Back-to-back lookups 1,2,3.
    cyc();
    wv = 1'b1; widx = 5'd1; wdata = 26'h0111111;
    cyc();
    widx = 5'd2; wdata = 26'h0222222;
    cyc();
    wv = 1'b0; lv = 1'b1; lidx = 5'd1;
    #1;
    check("b2b_acc1", {31'd0, lacc}, 32'd1);
    cyc();
    lidx = 5'd2;
    #1;
    check("b2b_acc2", {31'd0, lacc}, 32'd1);
    check("b2b_r1", {5'd0, rvalid, rdata}, {5'd0, 1'b1, 26'h0111111});
    cyc();
    lidx = 5'd3;
    #1;
    check("b2b_r2", {5'd0, rvalid, rdata}, {5'd0, 1'b1, 26'h0222222});
    cyc();
    lv = 1'b0;
    #1;
    check("b2b_r3", {5'd0, rvalid, rdata}, {5'd0, 1'b1, 26'h2AAAAAA});
    cyc();
    check("b2b_idle", {31'd0, rvalid}, 32'd0);

    // Fill every entry, then flush with a coincident write and lookup.
    for (int i = 0; i < 32; i++) begin
      wv = 1'b1; widx = 5'(i); wdata = 26'(i + 1);
      cyc();
    end
    flush = 1'b1;
    wv = 1'b1; widx = 5'd9; wdata = 26'h3C3C3C3;
    lv = 1'b1; lidx = 5'd4;
    #1;
    check("fl_acc", {29'd0, busy, lacc, wacc}, 32'd3);
    cyc();
    flush = 1'b0; wv = 1'b0; lv = 1'b0;
    #1;
    check("fl_resp", {5'd0, rvalid, rdata}, {5'd0, 1'b1, 26'd5});
    run_clear(1'b1);
    lv = 1'b1; lidx = 5'd0;
    #1;
    check("fl_acc0", {31'd0, lacc}, 32'd1);
    cyc();
    lidx = 5'd31;
    #1;
    check("fl_rd0", {5'd0, rvalid, rdata}, {5'd0, 1'b1, 26'd0});
    cyc();
    lv = 1'b0;
    #1;
    check("fl_rd31", {5'd0, rvalid, rdata}, {5'd0, 1'b1, 26'd0});

    // Reset while a lookup response is pending.
    cyc();
    lv = 1'b1; lidx = 5'd0;
    #1;
    check("rl_acc", {31'd0, lacc}, 32'd1);
    cyc();
    lv = 1'b0; rst = 1'b1;
    #1;
    check("rl_drop", {4'd0, rvalid, csb0, rdata}, {4'd0, 1'b0, 1'b1, 26'd0});
    cyc();
    rst = 1'b0;

    // Partial clear up to index 17, then reset restarts it from 0.
    for (int i = 0; i < 17; i++) begin
      #1;
      check("pc_addr", {26'd0, csb0, addr0}, {26'd0, 1'b0, 5'(i)});
      cyc();
    end
    #1;
    check("pc_addr17", {26'd0, csb0, addr0}, {26'd0, 1'b0, 5'd17});
    rst = 1'b1;
    #1;
    check("pc_rst", {30'd0, busy, csb0}, 32'd3);
    cyc();
    rst = 1'b0;
    run_clear(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
